befehl_lader: RTL

Instruction-fetch unit feeding the processor control unit. Upon a fetch request from control (`LoadBefehlSignal`), it reads one instruction word from instruction memory over a ready-handshake bus, latches it, and answers with a one-cycle `BefehlGeladen` pulse. It also owns the program counter, which it advances or redirects on the control unit's `PCSignal`/`PCSprungSignal` commands. It sits between control/decode and instruction memory.

---
 rtl/steuerung_pkg.sv | 16 +
 rtl/befehl_pc.sv | 31 +++
 rtl/befehl_lader.sv | 118 +++++++++++
 3 files changed

// File: rtl/steuerung_pkg.sv
// Shared definitions for the instruction fetch path: fetch FSM states,
// instruction size in bytes and the default bus widths.
package steuerung_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ANFRAGE = 2'd1,
        FERTIG  = 2'd2,
        FEHLER  = 2'd3
    } lade_zustand_t;

    localparam int BEFEHL_BYTES       = 4;
    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/befehl_pc.sv
// Program counter register: sequential advance by one instruction or a
// word-aligned jump. The low two target bits are dropped so the PC can never
// become misaligned.
module befehl_pc
    import steuerung_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  update,
    input  logic                  sprung,
    input  logic [ADDR_WIDTH-1:0] sprungziel,
    output logic [ADDR_WIDTH-1:0] pc
);

    // PC register; the increment wraps naturally at the top of the address space.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pc <= RESET_PC;
        end else if (update) begin
            if (sprung) begin
                pc <= {sprungziel[ADDR_WIDTH-1:2], 2'b00};
            end else begin
                pc <= pc + ADDR_WIDTH'(BEFEHL_BYTES);
            end
        end
    end

endmodule

// File: rtl/befehl_lader.sv
// Instruction fetch unit. On a request level from control it reads one word
// from instruction memory, latches it and pulses BefehlGeladen for one cycle.
// A request must be seen low once before another fetch is accepted (armed).
// A memory that never answers traps the unit in FEHLER until reset.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for an armed fetch request
//   ANFRAGE | read request on the bus, waiting for SpeicherBereit
//   FERTIG  | Befehl valid, one-cycle BefehlGeladen pulse
//   FEHLER  | memory timed out; sticky Busfehler, left only by Reset
module befehl_lader
    import steuerung_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    TIMEOUT    = 255
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  LoadBefehlSignal,
    input  logic                  PCSignal,
    input  logic                  PCSprungSignal,
    input  logic [ADDR_WIDTH-1:0] Sprungziel,
    input  logic                  SpeicherBereit,
    input  logic [DATA_WIDTH-1:0] SpeicherDaten,
    output logic                  SpeicherLesen,
    output logic [ADDR_WIDTH-1:0] SpeicherAdresse,
    output logic [DATA_WIDTH-1:0] Befehl,
    output logic                  BefehlGeladen,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic                  Busfehler
);

    // Counter only needs to reach TIMEOUT-1.
    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lade_zustand_t    state;
    logic             armed;
    logic [CNT_W-1:0] wait_cnt;
    logic             pc_update;

    // The PC freezes once the bus has failed.
    assign pc_update = PCSignal && (state != FEHLER);

    befehl_pc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc (
        .Clock      (Clock),
        .Reset      (Reset),
        .update     (pc_update),
        .sprung     (PCSprungSignal),
        .sprungziel (Sprungziel),
        .pc         (PC)
    );

    // Fetch FSM with registered bus/handshake outputs, address latch,
    // timeout counter and instruction latch.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state           <= IDLE;
            armed           <= 1'b1;
            wait_cnt        <= '0;
            SpeicherAdresse <= RESET_PC;
            Befehl          <= '0;
            SpeicherLesen   <= 1'b0;
            BefehlGeladen   <= 1'b0;
            Busfehler       <= 1'b0;
        end else begin
            BefehlGeladen <= 1'b0;
            // A low request always re-arms, even in the FERTIG cycle.
            if (!LoadBefehlSignal) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (LoadBefehlSignal && armed) begin
                        SpeicherAdresse <= PC;
                        wait_cnt        <= '0;
                        SpeicherLesen   <= 1'b1;
                        state           <= ANFRAGE;
                    end
                end
                ANFRAGE: begin
                    if (SpeicherBereit) begin
                        Befehl        <= SpeicherDaten;
                        SpeicherLesen <= 1'b0;
                        BefehlGeladen <= 1'b1;
                        state         <= FERTIG;
                    end else if (wait_cnt == CNT_LAST) begin
                        SpeicherLesen <= 1'b0;
                        Busfehler     <= 1'b1;
                        state         <= FEHLER;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                FERTIG: begin
                    if (LoadBefehlSignal) begin
                        armed <= 1'b0;
                    end
                    state <= IDLE;
                end
                FEHLER: begin
                    SpeicherLesen <= 1'b0;
                    Busfehler     <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
